// File: rtl/reg_sb_pkg.sv
// ============================================================================
// Module      : reg_sb_pkg
// Description : Shared widths, vector types and popcount helper for the
//               register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_sb_pkg;

  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2**ADDR_W;
  // Widest busy vector the popcount helper accepts (ADDR_W up to 8).
  localparam int MAX_REGS = 256;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REGS; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ============================================================================
// Module      : onehot_decoder
// Description : Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder #(
  parameter int ADDR_W = 3
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Busy-bit scoreboard stalling issue on RAW/WAW hazards and
//               producing a registered one-hot register-file write enable.
//               Optional macro REG_SB_ZERO_REG_EN hardwires register 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter  int ADDR_W   = reg_sb_pkg::ADDR_W,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic [ADDR_W-1:0]   issue_src1,
  input  logic [ADDR_W-1:0]   issue_src2,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     pending_cnt,
  output logic                wb_err
);

  import reg_sb_pkg::*;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W:0]     pending_cnt_q, pending_cnt_d;
  logic                wb_err_q, wb_err_d;

  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic                w_fire;
  logic                w_set_en;
  logic                w_clr_en;

  // No writeback bypass: readiness looks only at the registered busy bits.
  assign issue_ready = !busy_q[issue_dest] && !busy_q[issue_src1] && !busy_q[issue_src2];
  assign w_fire      = issue_valid && issue_ready;

`ifdef REG_SB_ZERO_REG_EN
  assign w_set_en = w_fire && (issue_dest != '0);
  assign w_clr_en = wb_valid && (wb_dest != '0);
`else
  assign w_set_en = w_fire;
  assign w_clr_en = wb_valid;
`endif

  onehot_decoder #(.ADDR_W(ADDR_W)) u_set_dec (
    .en     (w_set_en),
    .addr   (issue_dest),
    .onehot (w_set_mask)
  );

  onehot_decoder #(.ADDR_W(ADDR_W)) u_clr_dec (
    .en     (w_clr_en),
    .addr   (wb_dest),
    .onehot (w_clr_mask)
  );

  // Set is applied after clear so a fire onto a non-busy writeback target ends busy.
  always_comb begin
    busy_d        = (busy_q & ~w_clr_mask) | w_set_mask;
    wr_en_d       = w_clr_mask;
    wb_err_d      = wb_err_q | (w_clr_en && !busy_q[wb_dest]);
    pending_cnt_d = (ADDR_W+1)'(popcount(MAX_REGS'(busy_d)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= '0;
      wr_en_q       <= '0;
      pending_cnt_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      wr_en_q       <= wr_en_d;
      pending_cnt_q <= pending_cnt_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign busy        = busy_q;
  assign wr_en       = wr_en_q;
  assign pending_cnt = pending_cnt_q;
  assign wb_err      = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Self-checking bench for reg_scoreboard with a set-based
//               reference model of outstanding writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

  import reg_sb_pkg::*;

`ifdef REG_SB_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_dest, issue_src1, issue_src2;
  logic                issue_ready;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_dest;
  logic [NUM_REGS-1:0] wr_en, busy;
  logic [ADDR_W:0]     pending_cnt;
  logic                wb_err;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: set of registers with an outstanding write.
  bit m_out [NUM_REGS];
  int m_wr_idx;     // register written back last cycle, -1 if none
  bit m_err;

  reg_scoreboard #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_src1  (issue_src1),
    .issue_src2  (issue_src2),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wr_en       (wr_en),
    .busy        (busy),
    .pending_cnt (pending_cnt),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    return !(m_out[issue_dest] || m_out[issue_src1] || m_out[issue_src2]);
  endfunction

  function automatic logic [NUM_REGS-1:0] m_busy_vec();
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) if (m_out[i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int m_count();
    int n;
    n = 0;
    for (int i = 0; i < NUM_REGS; i++) if (m_out[i]) n++;
    return n;
  endfunction

  function automatic logic [NUM_REGS-1:0] m_wr_vec();
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (m_wr_idx >= 0) v[m_wr_idx] = 1'b1;
    return v;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    bit nxt [NUM_REGS];
    int nwr;
    bit nerr;
    bit rdy;
    rdy  = m_ready();
    nxt  = m_out;
    nwr  = -1;
    nerr = m_err;
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) nxt[i] = 1'b0;
      nerr = 1'b0;
    end else begin
      if (wb_valid && !(ZERO_EN && wb_dest == 0)) begin
        if (!m_out[wb_dest]) nerr = 1'b1;
        nxt[wb_dest] = 1'b0;
        nwr = int'(wb_dest);
      end
      if (issue_valid && rdy && !(ZERO_EN && issue_dest == 0))
        nxt[issue_dest] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_out    = nxt;
    m_wr_idx = nwr;
    m_err    = nerr;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_dest  = '0;
    issue_src1  = '0;
    issue_src2  = '0;
    wb_valid    = 1'b0;
    wb_dest     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (busy !== '0) begin n_mis++; $display("FAIL reset_busy: got %h expected 0", busy); end
    n_cmp++; if (pending_cnt !== '0) begin n_mis++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt); end
    n_cmp++; if (wr_en !== '0) begin n_mis++; $display("FAIL reset_wr_en: got %h expected 0", wr_en); end
    n_cmp++; if (wb_err !== 1'b0) begin n_mis++; $display("FAIL reset_wb_err: got %b expected 0", wb_err); end
    for (int k = 0; k < 8; k++) begin
      issue_dest = ADDR_W'($urandom); issue_src1 = ADDR_W'($urandom); issue_src2 = ADDR_W'($urandom);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_mis++; $display("FAIL idle_ready: got %b expected 1", issue_ready); end
    end
    idle_inputs();
  endtask

  task automatic test_issue_wb();
    issue_valid = 1'b1; issue_dest = 3'd5; issue_src1 = 3'd1; issue_src2 = 3'd2;
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (busy !== 8'b0010_0000) begin n_mis++; $display("FAIL issue5_busy: got %b expected 00100000", busy); end
    n_cmp++; if (pending_cnt !== 4'd1) begin n_mis++; $display("FAIL issue5_cnt: got %0d expected 1", pending_cnt); end
    issue_dest = 3'd0; issue_src1 = 3'd5; issue_src2 = 3'd0;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_mis++; $display("FAIL raw_stall: got %b expected 0", issue_ready); end
    wb_valid = 1'b1; wb_dest = 3'd5;
    tick();
    wb_valid = 1'b0;
    n_cmp++; if (busy !== '0) begin n_mis++; $display("FAIL wb5_busy: got %b expected 0", busy); end
    n_cmp++; if (wr_en !== 8'b0010_0000) begin n_mis++; $display("FAIL wb5_wr_en: got %b expected 00100000", wr_en); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_mis++; $display("FAIL raw_release: got %b expected 1", issue_ready); end
    tick();
    n_cmp++; if (wr_en !== '0) begin n_mis++; $display("FAIL wr_en_pulse: got %b expected 0", wr_en); end
    idle_inputs();
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_dest = 3'd3; issue_src1 = 3'd1; issue_src2 = 3'd2;
    tick();
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_mis++; $display("FAIL waw_stall: got %b expected 0", issue_ready); end
    wb_valid = 1'b1; wb_dest = 3'd3;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_mis++; $display("FAIL waw_no_bypass: got %b expected 0", issue_ready); end
    issue_valid = 1'b0;
    tick();
    wb_valid = 1'b0;
    n_cmp++; if (issue_ready !== 1'b1) begin n_mis++; $display("FAIL waw_release: got %b expected 1", issue_ready); end
    n_cmp++; if (wb_err !== 1'b0) begin n_mis++; $display("FAIL waw_no_err: got %b expected 0", wb_err); end
    idle_inputs();
  endtask

  task automatic test_fill_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      issue_valid = 1'b1; issue_dest = ADDR_W'(i); issue_src1 = ADDR_W'(i); issue_src2 = ADDR_W'(i);
      tick();
    end
    issue_valid = 1'b0;
    n_cmp++; if (pending_cnt !== (ZERO_EN ? 4'd7 : 4'd8)) begin n_mis++; $display("FAIL full_cnt: got %0d expected %0d", pending_cnt, ZERO_EN ? 7 : 8); end
    n_cmp++; if (busy !== (ZERO_EN ? 8'hFE : 8'hFF)) begin n_mis++; $display("FAIL full_busy: got %h expected %h", busy, ZERO_EN ? 8'hFE : 8'hFF); end
    issue_dest = 3'd1; issue_src1 = 3'd1; issue_src2 = 3'd1;
    #1;
    n_cmp++; if (issue_ready !== 1'b0) begin n_mis++; $display("FAIL full_ready: got %b expected 0", issue_ready); end
    reset = 1'b1; wb_valid = 1'b1; wb_dest = 3'd2; issue_valid = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    n_cmp++; if ({busy, wr_en, pending_cnt, wb_err} !== '0) begin n_mis++; $display("FAIL mid_reset: got busy=%h wr_en=%h cnt=%0d err=%b expected all 0", busy, wr_en, pending_cnt, wb_err); end
  endtask

  task automatic test_wb_err();
    wb_valid = 1'b1; wb_dest = 3'd6;
    tick();
    wb_valid = 1'b0;
    n_cmp++; if (wb_err !== 1'b1) begin n_mis++; $display("FAIL err_set: got %b expected 1", wb_err); end
    n_cmp++; if (wr_en !== 8'b0100_0000) begin n_mis++; $display("FAIL err_wr_en: got %b expected 01000000", wr_en); end
    issue_valid = 1'b1; issue_dest = 3'd4; issue_src1 = 3'd1; issue_src2 = 3'd2;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b1; wb_dest = 3'd4;
    tick();
    wb_valid = 1'b0;
    tick();
    n_cmp++; if (wb_err !== 1'b1) begin n_mis++; $display("FAIL err_sticky: got %b expected 1", wb_err); end
    idle_inputs();
  endtask

  // Fire onto a free register while writing that same register back.
  task automatic test_set_wins();
    do_reset();
    issue_valid = 1'b1; issue_dest = 3'd2; issue_src1 = 3'd0; issue_src2 = 3'd0;
    wb_valid = 1'b1; wb_dest = 3'd2;
    tick();
    idle_inputs();
    n_cmp++; if (busy !== 8'b0000_0100) begin n_mis++; $display("FAIL set_wins_busy: got %b expected 00000100", busy); end
    n_cmp++; if (wb_err !== 1'b1) begin n_mis++; $display("FAIL set_wins_err: got %b expected 1", wb_err); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    issue_valid = 1'b1; issue_dest = 3'd0; issue_src1 = 3'd3; issue_src2 = 3'd4;
    tick();
    issue_valid = 1'b0;
    n_cmp++; if (busy !== '0) begin n_mis++; $display("FAIL zero_busy: got %b expected 0", busy); end
    wb_valid = 1'b1; wb_dest = 3'd0;
    tick();
    wb_valid = 1'b0;
    n_cmp++; if (wr_en !== '0) begin n_mis++; $display("FAIL zero_wr_en: got %b expected 0", wr_en); end
    n_cmp++; if (wb_err !== 1'b0) begin n_mis++; $display("FAIL zero_err: got %b expected 0", wb_err); end
    issue_dest = 3'd5; issue_src1 = 3'd0; issue_src2 = 3'd0;
    #1;
    n_cmp++; if (issue_ready !== 1'b1) begin n_mis++; $display("FAIL zero_src: got %b expected 1", issue_ready); end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 59) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_dest  = ADDR_W'($urandom);
      issue_src1  = ADDR_W'($urandom);
      issue_src2  = ADDR_W'($urandom);
      wb_valid    = $urandom_range(0, 2) != 0;
      wb_dest     = ADDR_W'($urandom);
      // Mostly write back something actually outstanding.
      if ($urandom_range(0, 7) != 0) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (m_out[(int'(wb_dest) + k) % NUM_REGS]) begin
            wb_dest = ADDR_W'((int'(wb_dest) + k) % NUM_REGS);
            break;
          end
        end
      end
      #1;
      n_cmp++; if (issue_ready !== m_ready()) begin n_mis++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, issue_ready, m_ready()); end
      tick();
      n_cmp++;
      if (busy !== m_busy_vec() || wr_en !== m_wr_vec() || pending_cnt !== (ADDR_W+1)'(m_count()) || wb_err !== m_err) begin
        n_mis++;
        $display("FAIL rnd_state c=%0d: got busy=%h wr_en=%h cnt=%0d err=%b expected busy=%h wr_en=%h cnt=%0d err=%b",
                 c, busy, wr_en, pending_cnt, wb_err, m_busy_vec(), m_wr_vec(), m_count(), m_err);
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NUM_REGS; i++) m_out[i] = 1'b0;
    m_wr_idx = -1;
    m_err    = 1'b0;
    test_reset();
    test_issue_wb();
    test_waw();
    test_fill_reset();
    test_wb_err();
    test_set_wins();
    if (ZERO_EN) test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
